// File: rtl/tpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : tpu_pkg
// Purpose  : Shared definitions for the multi-lane TPU MAC datapath:
//            default widths, sign-magnitude decode helpers and saturation
//            bound helpers derived from the accumulator width.
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

package tpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 17;
    localparam int LANES_DEF  = 4;

    // Operands are passed zero-extended to 64 bits with their real width
    // alongside, so one helper serves any parameterisation.
    function automatic logic sm_sign(input logic [63:0] v, input int unsigned w);
        return 1'(v >> (w - 1));
    endfunction

    function automatic logic [63:0] sm_mag(input logic [63:0] v, input int unsigned w);
        return v & ((64'd1 << (w - 1)) - 64'd1);
    endfunction

    // True for both +0 and -0 (sign bit alone set).
    function automatic logic sm_is_zero(input logic [63:0] v, input int unsigned w);
        return sm_mag(v, w) == 64'd0;
    endfunction

    // Two's-complement bounds of a w-bit accumulator; callers keep the low
    // w bits.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return ~64'd0 << (w - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_mac_lane.sv
//------------------------------------------------------------------------------
// Module   : tpu_mac_lane
// Purpose  : One sign-magnitude MAC lane. Stage 1 registers the product
//            sign/magnitude, stage 2 accumulates into a two's-complement
//            accumulator with saturate or wrap on overflow and a sticky
//            overflow flag.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            in_valid, a, b  - operands (sign-magnitude) consumed this cycle
//            sat_mode        - 1 = saturate, 0 = wrap
//            clr             - clear accumulator and error (dump with clear)
//            acc_next        - value the accumulator takes this edge (snapshot)
//            error           - sticky overflow flag
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_mac_lane
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sat_mode,
    input  logic              clr,
    output logic [ACC_W-1:0]  acc_next,
    output logic              error
);

    localparam int c_MAG_W  = DATA_W - 1;
    localparam int c_PROD_W = 2 * c_MAG_W;

    localparam logic [ACC_W-1:0] c_SAT_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] c_SAT_MIN = ACC_W'(sat_min(ACC_W));

    logic [c_MAG_W-1:0]  w_mag_a;
    logic [c_MAG_W-1:0]  w_mag_b;
    logic [c_PROD_W-1:0] w_prod;
    logic                w_sign;
    logic                w_zero;

    logic                r_s1_valid;
    logic                r_s1_sign;
    logic [c_PROD_W-1:0] r_s1_mag;

    logic [ACC_W-1:0]    r_acc;
    logic                r_error;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_addend;
    logic [ACC_W:0]      w_sum;
    logic                w_ovf;
    logic [ACC_W-1:0]    w_acc_add;

    // ---------------- stage 1: multiply ----------------
    assign w_mag_a = c_MAG_W'(sm_mag(64'(a), DATA_W));
    assign w_mag_b = c_MAG_W'(sm_mag(64'(b), DATA_W));
    assign w_prod  = c_PROD_W'(w_mag_a) * c_PROD_W'(w_mag_b);
    assign w_sign  = sm_sign(64'(a), DATA_W) ^ sm_sign(64'(b), DATA_W);
    // A zero product must never carry a negative sign (e.g. -0 * x).
    assign w_zero  = sm_is_zero(64'(a), DATA_W) | sm_is_zero(64'(b), DATA_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sign & ~w_zero;
                r_s1_mag  <= w_prod;
            end
        end
    end

    // ---------------- stage 2: accumulate ----------------
    assign w_prod_ext = ACC_W'(r_s1_mag);
    assign w_addend   = r_s1_sign ? (~w_prod_ext + 1'b1) : w_prod_ext;
    // One guard bit: overflow shows as disagreement between the top two bits.
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + {w_addend[ACC_W-1], w_addend};
    assign w_ovf      = r_s1_valid & (w_sum[ACC_W] != w_sum[ACC_W-1]);

    always_comb begin
        w_acc_add = w_sum[ACC_W-1:0];
        if (w_ovf && sat_mode) begin
            w_acc_add = w_sum[ACC_W] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

    assign acc_next = r_s1_valid ? w_acc_add : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_error <= 1'b0;
        end else if (clr) begin
            // Snapshot already captured acc_next; an overflow on this edge
            // is visible in the dump only.
            r_acc   <= '0;
            r_error <= 1'b0;
        end else begin
            r_acc   <= acc_next;
            r_error <= r_error | w_ovf;
        end
    end

    assign error = r_error;

endmodule

`default_nettype wire

// File: rtl/tpu_mac_vector.sv
//------------------------------------------------------------------------------
// Module   : tpu_mac_vector
// Purpose  : LANES independent sign-magnitude MAC lanes with shared dump /
//            clear control and a registered result snapshot.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            in_valid          - operands on input1/input2 consumed this cycle
//            input1, input2    - lane i operand at [i*DATA_W +: DATA_W]
//            out_HL            - dump strobe (snapshot accumulators into out)
//            acc_clr           - with out_HL, clear accumulators and errors
//            sat_mode          - 1 = saturate, 0 = wrap on overflow
//            out               - last dump, lane i at [i*ACC_W +: ACC_W]
//            out_valid         - high for the cycle following a dump edge
//            error             - per-lane sticky overflow flags
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_mac_vector
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [LANES*DATA_W-1:0] input1,
    input  logic [LANES*DATA_W-1:0] input2,
    input  logic                    out_HL,
    input  logic                    acc_clr,
    input  logic                    sat_mode,
    output logic [LANES*ACC_W-1:0]  out,
    output logic                    out_valid,
    output logic [LANES-1:0]        error
);

    logic                   w_clr;
    logic [LANES*ACC_W-1:0] w_acc_next;
    logic [LANES*ACC_W-1:0] r_out;
    logic                   r_out_valid;

    // acc_clr is meaningful only together with a dump.
    assign w_clr = out_HL & acc_clr;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        tpu_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid),
            .a        (input1[gi*DATA_W +: DATA_W]),
            .b        (input2[gi*DATA_W +: DATA_W]),
            .sat_mode (sat_mode),
            .clr      (w_clr),
            .acc_next (w_acc_next[gi*ACC_W +: ACC_W]),
            .error    (error[gi])
        );
    end

    // Snapshot takes acc_next so an accumulate committing on the dump edge
    // is included.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= out_HL;
            if (out_HL) begin
                r_out <= w_acc_next;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_tpu_mac_vector.sv
//------------------------------------------------------------------------------
// Module   : tb_tpu_mac_vector
// Purpose  : Directed self-checking bench for tpu_mac_vector with
//            hand-computed expected values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tpu_mac_vector;

    localparam int DW = 8;
    localparam int AW = 17;
    localparam int L  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [L*DW-1:0] input1;
    logic [L*DW-1:0] input2;
    logic            out_HL;
    logic            acc_clr;
    logic            sat_mode;
    logic [L*AW-1:0] out;
    logic            out_valid;
    logic [L-1:0]    error;

    int n_checks = 0;
    int n_errors = 0;

    tpu_mac_vector #(.DATA_W(DW), .ACC_W(AW), .LANES(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .input1    (input1),
        .input2    (input2),
        .out_HL    (out_HL),
        .acc_clr   (acc_clr),
        .sat_mode  (sat_mode),
        .out       (out),
        .out_valid (out_valid),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are read 1 time unit after it and inputs
    // change there too, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] lane_out(input int i);
        return out[i*AW +: AW];
    endfunction

    task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        input1[i*DW +: DW] = a;
        input2[i*DW +: DW] = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        out_HL   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    // Feed lane 0 one operand pair for one cycle.
    task automatic feed0(input logic [DW-1:0] a, input logic [DW-1:0] b);
        idle();
        in_valid = 1'b1;
        set_ops(0, a, b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic dump(input logic clr);
        idle();
        out_HL  = 1'b1;
        acc_clr = clr;
        tick();
        idle();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        input1   = '0;
        input2   = '0;
        out_HL   = 1'b0;
        acc_clr  = 1'b0;
        sat_mode = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_error", 64'(error), 64'd0);

        // Basic MAC: 195 + 1927 - 81 = 2041
        feed0(8'd13, 8'd15);
        feed0(8'd41, 8'd47);
        feed0(8'h89, 8'd9);
        dump(1'b0);
        check("mac_out", 64'(lane_out(0)), 64'd2041);
        check("mac_out_valid", 64'(out_valid), 64'd1);
        check("mac_error", 64'(error), 64'd0);
        tick();
        check("mac_pulse_low", 64'(out_valid), 64'd0);
        check("mac_out_hold", 64'(lane_out(0)), 64'd2041);

        // Dump with clear, then 1x1 and (-9)x(-2) = +18
        dump(1'b1);
        check("clr_snapshot", 64'(lane_out(0)), 64'd2041);
        feed0(8'd1, 8'd1);
        idle();
        in_valid = 1'b1;
        set_ops(0, 8'h89, 8'h82);
        out_HL   = 1'b1;
        tick();
        check("latency_dump", 64'(lane_out(0)), 64'd1);
        dump(1'b0);
        check("neg_neg_dump", 64'(lane_out(0)), 64'd19);
        check("b2b_out_valid", 64'(out_valid), 64'd1);
        dump(1'b1);

        // Saturation: 5 x 16129 = 80645 -> clamp 65535
        sat_mode = 1'b1;
        for (int k = 0; k < 5; k++) feed0(8'd127, 8'd127);
        tick();
        check("sat_error_set", 64'(error), 64'b0001);
        feed0(8'd1, 8'd1);
        tick();
        check("sat_error_sticky", 64'(error), 64'b0001);
        dump(1'b0);
        check("sat_out", 64'(lane_out(0)), 64'd65535);
        check("sat_error_after_dump", 64'(error), 64'b0001);
        dump(1'b1);
        check("sat_error_cleared", 64'(error), 64'd0);

        // Wrap: 80645 - 131072 = -50427 (17-bit pattern 0x13B05)
        sat_mode = 1'b0;
        for (int k = 0; k < 5; k++) feed0(8'd127, 8'd127);
        tick();
        check("wrap_error_set", 64'(error), 64'b0001);
        dump(1'b1);
        check("wrap_out", 64'(lane_out(0)), 64'h13B05);

        // Negative zero leaves the accumulator untouched
        feed0(8'd2, 8'd3);
        feed0(8'h80, 8'h05);
        feed0(8'h05, 8'h80);
        tick();
        dump(1'b1);
        check("negzero_out", 64'(lane_out(0)), 64'd6);
        check("negzero_error", 64'(error), 64'd0);

        // All lanes: lane i accumulates (i+1)*(i+2) three times
        idle();
        for (int i = 0; i < L; i++) set_ops(i, 8'(i + 1), 8'(i + 2));
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        idle();
        tick();
        dump(1'b1);
        check("lane0", 64'(lane_out(0)), 64'd6);
        check("lane1", 64'(lane_out(1)), 64'd18);
        check("lane2", 64'(lane_out(2)), 64'd36);
        check("lane3", 64'(lane_out(3)), 64'd60);

        // Overflow on lane 2 only
        sat_mode = 1'b1;
        idle();
        for (int i = 0; i < L; i++) set_ops(i, 8'd1, 8'd1);
        set_ops(2, 8'd127, 8'd127);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        idle();
        tick();
        check("lane2_only_error", 64'(error), 64'b0100);
        dump(1'b1);
        check("lane2_sat", 64'(lane_out(2)), 64'd65535);
        check("lane3_small", 64'(lane_out(3)), 64'd5);

        // Reset with stage 1 full and a dump pending
        feed0(8'd5, 8'd5);
        in_valid = 1'b1;
        out_HL   = 1'b1;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("reset_out", 64'(out), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        tick();
        tick();
        dump(1'b0);
        check("reset_acc_zero", 64'(lane_out(0)), 64'd0);
        check("reset_error", 64'(error), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
